// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the MEM stage: EX->MEM, MEM->WB and forward bundles.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_stage_pkg;

  localparam int TO_MEM_DATA_WIDTH = 77;
  localparam int TO_WB_DATA_WIDTH  = 71;
  localparam int MEM_FORWARD_WIDTH = 38;

  localparam logic [2:0] MEM_OP_B  = 3'b000;
  localparam logic [2:0] MEM_OP_H  = 3'b001;
  localparam logic [2:0] MEM_OP_W  = 3'b010;
  localparam logic [2:0] MEM_OP_BU = 3'b100;
  localparam logic [2:0] MEM_OP_HU = 3'b101;

  // MSB-first field order matches the flat EX->MEM bus layout
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic        gr_we;
    logic        res_from_mem;
    logic [2:0]  mem_op;
    logic        req_issued;
    logic        ex_sys;
    logic        rsv;
  } to_mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [31:0] final_result;
    logic        gr_we;
    logic        ex_sys;
  } to_wb_t;

  typedef struct packed {
    logic        load_pending;
    logic [4:0]  dest;
    logic [31:0] result;
  } mem_fwd_t;

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of EX/SRAM/WB-facing signals of the MEM stage; slave = MEM stage, master = neighbours.
// Latency: n/a (wires only).
// Backpressure: valid/allow_in pairs on both sides; mem_stall_cnt present only with MEM_STALL_CNT_EN.
interface mem_stage_if;
  import mem_stage_pkg::*;

  to_mem_t     to_MEM_data;
  logic        EX_to_MEM_valid;
  logic        MEM_allow_in;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  to_wb_t      to_WB_data;
  logic        MEM_to_WB_valid;
  logic        WB_allow_in;
  mem_fwd_t    MEM_forward;
  logic        mem_ex;
  logic        wb_ex;
`ifdef MEM_STALL_CNT_EN
  logic [31:0] mem_stall_cnt;
`endif

  modport slave (
    input  to_MEM_data, EX_to_MEM_valid, data_sram_data_ok, data_sram_rdata,
    input  WB_allow_in, wb_ex,
`ifdef MEM_STALL_CNT_EN
    output mem_stall_cnt,
`endif
    output MEM_allow_in, to_WB_data, MEM_to_WB_valid, MEM_forward, mem_ex
  );

  modport master (
    output to_MEM_data, EX_to_MEM_valid, data_sram_data_ok, data_sram_rdata,
    output WB_allow_in, wb_ex,
`ifdef MEM_STALL_CNT_EN
    input  mem_stall_cnt,
`endif
    input  MEM_allow_in, to_WB_data, MEM_to_WB_valid, MEM_forward, mem_ex
  );

endinterface

// File: rtl/mem_stage_load_extend.sv
// Picks the addressed byte/halfword of a load word and sign/zero-extends it to 32 bits.
// Latency: combinational.
// Backpressure: none.
module mem_stage_load_extend
  import mem_stage_pkg::*;
(
  input  logic [2:0]  mem_op,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // lane select by low address bits, then extend according to the load kind
  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    case (mem_op)
      MEM_OP_B:  result = {{24{byte_sel[7]}}, byte_sel};
      MEM_OP_H:  result = {{16{half_sel[15]}}, half_sel};
      MEM_OP_W:  result = rdata;
      MEM_OP_BU: result = {24'd0, byte_sel};
      MEM_OP_HU: result = {16'd0, half_sel};
      default:   result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: latches EX results, waits for data-SRAM response, extends loads; optional MEM_STALL_CNT_EN adds mem_stall_cnt.
// Latency: 1 cycle for non-memory ops; memory ops 1 cycle plus the data_ok wait.
// Backpressure: holds while WB_allow_in=0 (early response buffered); MEM_allow_in=0 until a flushed response drains.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  mem_stage_if.slave mif
);

  logic        mem_valid;
  to_mem_t     mem_r;
  logic [31:0] rdata_buf;
  logic        rdata_buf_valid;
  logic        discard_pending;

  logic        mem_ready_go;
  logic        allow_in;
  logic        load_fire;
  logic        buf_capture;
  logic [31:0] sel_rdata;
  logic [31:0] load_data;
  logic [31:0] final_result;
  logic        unused_rsv;

  assign unused_rsv   = mem_r.rsv;
  assign mem_ready_go = ~mem_r.req_issued | rdata_buf_valid | mif.data_sram_data_ok;
  assign allow_in     = ~discard_pending & (~mem_valid | (mem_ready_go & mif.WB_allow_in));
  assign load_fire    = mif.EX_to_MEM_valid & allow_in;
  // a response arriving while WB is stalled must be kept, the SRAM will not repeat it
  assign buf_capture  = mif.data_sram_data_ok & mem_valid & mem_r.req_issued & ~discard_pending
                      & ~rdata_buf_valid & ~mif.WB_allow_in & ~mif.wb_ex;
  assign sel_rdata    = rdata_buf_valid ? rdata_buf : mif.data_sram_rdata;

  mem_stage_load_extend u_load_extend (
    .mem_op (mem_r.mem_op),
    .offset (mem_r.alu_result[1:0]),
    .rdata  (sel_rdata),
    .result (load_data)
  );

  assign final_result = mem_r.res_from_mem ? load_data : mem_r.alu_result;

  // stage valid bit: a WB exception kills whatever sits here
  always_ff @(posedge clk) begin
    if (reset || mif.wb_ex) mem_valid <= 1'b0;
    else if (allow_in)      mem_valid <= mif.EX_to_MEM_valid;
  end

  // payload register from EX
  always_ff @(posedge clk) begin
    if (reset)          mem_r <= '0;
    else if (load_fire) mem_r <= mif.to_MEM_data;
  end

  // hold an early response until WB takes the instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_buf_valid <= 1'b0;
      rdata_buf       <= '0;
    end else if (load_fire) begin
      rdata_buf_valid <= 1'b0;
    end else if (buf_capture) begin
      rdata_buf_valid <= 1'b1;
      rdata_buf       <= mif.data_sram_rdata;
    end
  end

  // remember to swallow the response of a flushed, still-outstanding request
  always_ff @(posedge clk) begin
    if (reset)                                                        discard_pending <= 1'b0;
    else if (mif.wb_ex && mem_valid && mem_r.req_issued && !mem_ready_go) discard_pending <= 1'b1;
    else if (mif.data_sram_data_ok)                                   discard_pending <= 1'b0;
  end

  assign mif.MEM_allow_in    = allow_in;
  assign mif.MEM_to_WB_valid = mem_valid & mem_ready_go & ~mif.wb_ex;
  assign mif.mem_ex          = mem_valid & mem_r.ex_sys;
  assign mif.to_WB_data      = '{pc: mem_r.pc, dest: mem_r.dest, final_result: final_result,
                                 gr_we: mem_r.gr_we, ex_sys: mem_r.ex_sys};
  assign mif.MEM_forward     = '{load_pending: mem_valid & mem_r.res_from_mem & ~mem_ready_go,
                                 dest: mem_valid ? mem_r.dest : 5'd0,
                                 result: final_result};

`ifdef MEM_STALL_CNT_EN
  logic [31:0] stall_cnt;

  // saturating count of cycles spent waiting on the data SRAM
  always_ff @(posedge clk) begin
    if (reset)                                                    stall_cnt <= '0;
    else if (mem_valid && !mem_ready_go && (stall_cnt != '1))     stall_cnt <= stall_cnt + 32'd1;
  end

  assign mif.mem_stall_cnt = stall_cnt;
`endif

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
MEM stage of the 5-stage LoongArch pipeline, sitting between the EX stage and the WB stage.
- Latches EX results and waits for the data-SRAM response on loads.
- Extracts and extends load bytes/halfwords, then hands {pc, dest, final_result, gr_we, ex_SYS} to WB.
- Publishes a forwarding bundle to ID and handles flush by a WB-stage exception, including discarding a data response that is already in flight.

Parameters:
none (all widths come from constants.h: `to_MEM_data_width = 77, `to_WB_data_width = 71)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
to_MEM_data  in  77  {pc[31:0], dest[4:0], alu_result[31:0], gr_we, res_from_mem, mem_op[2:0], req_issued, ex_SYS, rsv}
EX_to_MEM_valid  in  1  EX holds a valid instruction
MEM_allow_in  out  1  MEM can accept this cycle
data_sram_data_ok  in  1  load/store response strobe, exactly one per issued request
data_sram_rdata  in  32  read data, valid with data_ok
to_WB_data  out  71  {pc, dest, final_result, gr_we, ex_SYS}
MEM_to_WB_valid  out  1  MEM output valid
WB_allow_in  in  1  WB can accept
MEM_forward  out  38  {MEM_load_pending, MEM_dest[4:0] (0 when invalid), MEM_result[31:0]}
mem_ex  out  1  MEM_valid & ex_SYS; EX suppresses new memory requests while high
wb_ex  in  1  flush from WB

Behaviour:
- State registers: MEM_valid, to_MEM_data_r, rdata_buf[31:0], rdata_buf_valid, discard_pending.
- Reset values: MEM_valid=0, rdata_buf_valid=0, discard_pending=0, to_MEM_data_r=0. Consequently MEM_to_WB_valid=0, mem_ex=0, MEM_forward=0, MEM_allow_in=1.
- Handshake:
  - MEM_ready_go = ~req_issued | rdata_buf_valid | data_sram_data_ok.
  - MEM_allow_in = ~discard_pending & (~MEM_valid | (MEM_ready_go & WB_allow_in)).
  - MEM_to_WB_valid = MEM_valid & MEM_ready_go & ~wb_ex.
- Pipeline register:
  - If reset | wb_ex: MEM_valid <= 0.
  - Else if MEM_allow_in: MEM_valid <= EX_to_MEM_valid.
  - to_MEM_data_r loads when EX_to_MEM_valid & MEM_allow_in; rdata_buf_valid clears on that load.
- Response buffering:
  - When data_ok arrives with MEM_valid & req_issued & ~discard_pending & ~(WB_allow_in at handoff), capture rdata into rdata_buf and set rdata_buf_valid.
  - Selected data = rdata_buf_valid ? rdata_buf : data_sram_rdata.
- Load extraction (offset = alu_result[1:0]):
  - mem_op 000 ld.b: sign-extend the selected byte.
  - 001 ld.h: sign-extend halfword offset[1]*16.
  - 010 ld.w: word as-is.
  - 100 ld.bu / 101 ld.hu: zero-extend.
  - Others: word.
  - final_result = res_from_mem ? load_data : alu_result.
- Stores: req_issued=1, res_from_mem=0. Wait for data_ok; the data is ignored.
- Flush:
  - On wb_ex, if MEM_valid & req_issued & ~MEM_ready_go (response outstanding): set discard_pending.
  - The next data_ok clears discard_pending and is dropped. MEM_allow_in stays 0 until then, which keeps at most one request in flight.
  - If data_ok and wb_ex arrive in the same cycle, that response is consumed and discard_pending is not set.
- Forward: MEM_load_pending = MEM_valid & res_from_mem & ~MEM_ready_go. While it is high, ID must stall rather than bypass.
- Latency: 1 cycle for non-memory instructions. Loads take 1 cycle + data_ok wait.

Optional Feature:
MEM_STALL_CNT_EN
- Defined: adds output mem_stall_cnt[31:0]. It increments each cycle MEM_valid & ~MEM_ready_go, resets to 0 and saturates at 0xFFFFFFFF.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- constants.h holds:
  - `to_MEM_data_width and the field offsets.
  - mem_op encodings (MEM_OP_B=3'b000, H=001, W=010, BU=100, HU=101).
  - `to_WB_data_width and the MEM_forward width.
- Sub-module load_extend (combinational: mem_op, offset, rdata -> 32-bit result) is natural and will be reused by the future cache path.

Test Plan:
1. add.w: alu_result=0x12345678, gr_we=1, req_issued=0 -> next cycle MEM_to_WB_valid=1, final_result=0x12345678, MEM_forward dest correct, load_pending=0.
2. ld.b with offset 3, data_ok two cycles late, rdata=0x80FF0011 -> load_pending=1 for 2 cycles, MEM_allow_in=0; then final_result=0xFFFFFF80.
3. ld.hu with offset 2, rdata=0xBEEF1234, data_ok while WB_allow_in=0 for 3 cycles -> rdata_buf holds the data; final_result=0x0000BEEF once WB accepts.
4. wb_ex while a load waits for data_ok -> MEM_valid=0, discard_pending=1, MEM_allow_in=0. Next data_ok (rdata=0xDEAD) is dropped, no WB valid, allow_in returns to 1.
5. wb_ex in the same cycle as data_ok -> no discard_pending, and the next EX instruction is accepted in the following cycle.
6. reset asserted mid-wait -> all outputs 0 next cycle, MEM_allow_in=1; with MEM_STALL_CNT_EN, the counter reads 0.
